// File: rtl/dbg_pkg.sv
// Shared definitions for the debug loader: FSM state encoding and the
// command/response byte values exchanged over the UART link.
package dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_CNT,
        LD_BYTE,
        LD_WRITE,
        RUN,
        STEP,
        SEND_WR,
        SEND_GO
    } state_t;

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_PAUSE = 8'h50;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;
    localparam logic [7:0] RSP_HALT  = 8'h48;

endpackage

// File: rtl/dbg_word_packer.sv
// Assembles four received bytes into one instruction word, little-endian:
// the first byte shifted in ends up in bits [7:0] once all four have arrived.
// The word is 32 bits wide: four bytes per instruction.
module dbg_word_packer #(
    parameter int NB_INSTRUCTION = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      shift,
    input  logic [7:0]                byte_in,
    output logic [NB_INSTRUCTION-1:0] word,
    output logic                      last
);

    logic [NB_INSTRUCTION-1:0] word_reg;
    logic [1:0]                cnt_reg;

    // Shift new bytes in at the top so earlier bytes move toward the LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_reg <= '0;
            cnt_reg  <= 2'd0;
        end else if (clear) begin
            word_reg <= '0;
            cnt_reg  <= 2'd0;
        end else if (shift) begin
            word_reg <= {byte_in, word_reg[NB_INSTRUCTION-1:8]};
            cnt_reg  <= cnt_reg + 2'd1;
        end
    end

    assign word = word_reg;
    // High while the byte about to be shifted is the fourth of the word.
    assign last = (cnt_reg == 2'd3);

endmodule

// File: rtl/dbg_loader.sv
// UART debug loader: accepts 'L' (load N words into IMEM), 'R' (run until the
// CPU halts), 'S' (single step) and answers with a one-byte reply.
// Optional build macro DBG_PAUSE_CMD_EN: while running, RX bytes are popped
// and 'P' stops the CPU; without it the RX FIFO is left untouched in RUN.
module dbg_loader
    import dbg_pkg::*;
#(
    parameter int NB_INSTRUCTION  = 32,
    parameter int IMEM_ADDR_WIDTH = 8,
    parameter int NB_UART_DATA    = 9
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic [NB_UART_DATA-1:0]    i_rx_data,
    input  logic                       i_rx_empty,
    input  logic                       i_tx_full,
    input  logic                       i_cpu_halt,
    output logic                       o_rd,
    output logic                       o_wr,
    output logic [NB_UART_DATA-1:0]    o_wdata,
    output logic                       o_tx_start,
    output logic                       o_imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    output logic [NB_INSTRUCTION-1:0]  o_imem_wdata,
    output logic                       o_cpu_en,
    output logic                       o_cpu_rst,
    output logic                       o_busy
);

    state_t     state_reg;
    logic [7:0] word_idx_reg;
    logic [7:0] word_total_reg;
    logic [7:0] reply_reg;
    logic       cpu_en_reg;
    logic       cpu_rst_reg;

    logic [7:0] rx_byte;
    logic       pop_state;
    logic       stop_run;
    logic       word_last;
    logic       unused_rx_msb;

    assign rx_byte       = i_rx_data[7:0];
    assign unused_rx_msb = ^i_rx_data[NB_UART_DATA-1:8];

    // Decide which states may pop the RX FIFO and whether RUN must stop.
    always_comb begin
        pop_state = (state_reg == IDLE) || (state_reg == LD_CNT) || (state_reg == LD_BYTE);
        stop_run  = i_cpu_halt;
`ifdef DBG_PAUSE_CMD_EN
        pop_state = pop_state || (state_reg == RUN);
        if (state_reg == RUN && !i_rx_empty && rx_byte == CMD_PAUSE) begin
            stop_run = 1'b1;
        end
`endif
    end

    // A pop is only ever requested when a byte is actually present.
    assign o_rd = pop_state && !i_rx_empty && !i_rst;

    dbg_word_packer #(
        .NB_INSTRUCTION(NB_INSTRUCTION)
    ) u_packer (
        .clk     (clk),
        .rst     (i_rst),
        .clear   ((state_reg == LD_CNT) && o_rd),
        .shift   ((state_reg == LD_BYTE) && o_rd),
        .byte_in (rx_byte),
        .word    (o_imem_wdata),
        .last    (word_last)
    );

    // Command sequencer: decodes bytes, counts words, controls the CPU.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            word_idx_reg   <= 8'd0;
            word_total_reg <= 8'd0;
            reply_reg      <= 8'd0;
            cpu_en_reg     <= 1'b0;
            cpu_rst_reg    <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (o_rd) begin
                        case (rx_byte)
                            CMD_LOAD: begin
                                cpu_rst_reg <= 1'b1;
                                cpu_en_reg  <= 1'b0;
                                state_reg   <= LD_CNT;
                            end
                            CMD_RUN: begin
                                cpu_rst_reg <= 1'b0;
                                cpu_en_reg  <= 1'b1;
                                state_reg   <= RUN;
                            end
                            CMD_STEP: begin
                                cpu_rst_reg <= 1'b0;
                                cpu_en_reg  <= 1'b1;
                                state_reg   <= STEP;
                            end
                            default: begin
                                reply_reg <= RSP_NAK;
                                state_reg <= SEND_WR;
                            end
                        endcase
                    end
                end
                LD_CNT: begin
                    if (o_rd) begin
                        word_total_reg <= rx_byte;
                        word_idx_reg   <= 8'd0;
                        if (rx_byte == 8'd0) begin
                            reply_reg <= RSP_ACK;
                            state_reg <= SEND_WR;
                        end else begin
                            state_reg <= LD_BYTE;
                        end
                    end
                end
                LD_BYTE: begin
                    if (o_rd && word_last) begin
                        state_reg <= LD_WRITE;
                    end
                end
                LD_WRITE: begin
                    // word_total_reg is at least 1 here, so total-1 never underflows.
                    word_idx_reg <= word_idx_reg + 8'd1;
                    if (word_idx_reg == word_total_reg - 8'd1) begin
                        reply_reg <= RSP_ACK;
                        state_reg <= SEND_WR;
                    end else begin
                        state_reg <= LD_BYTE;
                    end
                end
                RUN: begin
                    if (stop_run) begin
                        cpu_en_reg <= 1'b0;
                        reply_reg  <= RSP_HALT;
                        state_reg  <= SEND_WR;
                    end
                end
                STEP: begin
                    cpu_en_reg <= 1'b0;
                    reply_reg  <= RSP_ACK;
                    state_reg  <= SEND_WR;
                end
                SEND_WR: begin
                    if (!i_tx_full) begin
                        state_reg <= SEND_GO;
                    end
                end
                SEND_GO: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_wr        = (state_reg == SEND_WR) && !i_tx_full;
    assign o_wdata     = {{(NB_UART_DATA-8){1'b0}}, reply_reg};
    assign o_tx_start  = (state_reg == SEND_GO);
    assign o_imem_we   = (state_reg == LD_WRITE);
    assign o_imem_addr = IMEM_ADDR_WIDTH'(word_idx_reg);
    assign o_cpu_en    = cpu_en_reg;
    assign o_cpu_rst   = cpu_rst_reg;
    assign o_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_dbg_loader.sv
// Scoreboard bench for dbg_loader: an RX FIFO model feeds command bytes, a
// reference model pushes expected IMEM writes and TX replies into queues, and
// a monitor pops and compares whenever the DUT writes IMEM or pushes TX.
module tb_dbg_loader;
    import dbg_pkg::*;

    localparam int NB_I = 32;
    localparam int AW   = 8;
    localparam int NB_U = 9;

    logic            clk = 1'b0;
    logic            i_rst;
    logic [NB_U-1:0] i_rx_data;
    logic            i_rx_empty;
    logic            i_tx_full;
    logic            i_cpu_halt;
    logic            o_rd, o_wr, o_tx_start, o_imem_we, o_cpu_en, o_cpu_rst, o_busy;
    logic [NB_U-1:0] o_wdata;
    logic [AW-1:0]   o_imem_addr;
    logic [NB_I-1:0] o_imem_wdata;

    dbg_loader #(.NB_INSTRUCTION(NB_I), .IMEM_ADDR_WIDTH(AW), .NB_UART_DATA(NB_U)) dut (
        .clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty),
        .i_tx_full(i_tx_full), .i_cpu_halt(i_cpu_halt), .o_rd(o_rd), .o_wr(o_wr),
        .o_wdata(o_wdata), .o_tx_start(o_tx_start), .o_imem_we(o_imem_we),
        .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata), .o_cpu_en(o_cpu_en),
        .o_cpu_rst(o_cpu_rst), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc = 0, wr_cnt = 0, we_cnt = 0, en_cnt = 0;
    int last_pop_cyc = 0, last_wr_cyc = 0;
    bit rd_seen = 0;

    logic [7:0]    rx_q[$];
    logic [7:0]    exp_tx[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    logic [7:0]    ld_bytes[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void refresh();
        i_rx_empty = (rx_q.size() == 0);
        i_rx_data  = (rx_q.size() != 0) ? {1'b0, rx_q[0]} : '0;
    endfunction

    // RX FIFO model: pops the head one step after a posedge that saw o_rd.
    always @(posedge clk) begin
        logic pop_now;
        cyc++;
        pop_now = o_rd;
        #1;
        if (pop_now) begin
            if (rx_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL rd_on_empty: got o_rd=1 expected 0 at cycle %0d", cyc);
            end else begin
                void'(rx_q.pop_front());
                last_pop_cyc = cyc;
            end
        end
        refresh();
    end

    // Monitor: compares every IMEM write and TX push against the scoreboard.
    always @(negedge clk) begin
        if (o_cpu_en) en_cnt++;
        if (o_rd) rd_seen = 1;
        if (o_imem_we) begin
            we_cnt++;
            if (exp_addr.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_imem_we: got addr %0h data %0h expected none", o_imem_addr, o_imem_wdata);
            end else begin
                chk("imem_addr", o_imem_addr, exp_addr.pop_front());
                chk("imem_data", o_imem_wdata, exp_data.pop_front());
                chk("cpu_rst_during_load", o_cpu_rst, 1);
            end
        end
        if (o_wr) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (exp_tx.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_tx: got %0h expected none", o_wdata);
            end else begin
                chk("tx_byte", o_wdata, {1'b0, exp_tx.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        rx_q.push_back(b);
        refresh();
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            if (o_tx_start) seen = 1;
        end
        chk({name, "_tx_start_seen"}, seen, 1);
        tick();
        chk({name, "_back_idle"}, o_busy, 0);
        $display("txn %s done at cycle %0d", name, cyc);
    endtask

    task automatic wait_en(input string name);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (o_cpu_en) seen = 1;
        end
        chk({name, "_cpu_en_seen"}, seen, 1);
        chk({name, "_cpu_rst_low"}, o_cpu_rst, 0);
    endtask

    // Reference for a load: word i = little-endian pack of bytes 4i..4i+3.
    task automatic do_load(input int n);
        push(CMD_LOAD);
        push(8'(n));
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(AW'(i));
            exp_data.push_back(32'(ld_bytes[4*i]) + 32'(ld_bytes[4*i+1]) * 256 +
                               32'(ld_bytes[4*i+2]) * 65536 + 32'(ld_bytes[4*i+3]) * 16777216);
        end
        for (int i = 0; i < 4*n; i++) push(ld_bytes[i]);
        exp_tx.push_back(RSP_ACK);
        wait_done($sformatf("load_n%0d", n));
    endtask

    task automatic do_run(input int d);
        exp_tx.push_back(RSP_HALT);
        en_cnt = 0;
        push(CMD_RUN);
        wait_en("run");
        repeat (d) tick();
        i_cpu_halt = 1'b1;
        wait_done($sformatf("run_d%0d", d));
        i_cpu_halt = 1'b0;
        vectors++;
        if (en_cnt != d && en_cnt != d + 1) begin
            errors++;
            $display("FAIL run_en_cycles: got %0d expected %0d or %0d", en_cnt, d, d + 1);
        end
    endtask

    task automatic do_step();
        exp_tx.push_back(RSP_ACK);
        en_cnt = 0;
        push(CMD_STEP);
        wait_done("step");
        chk("step_en_cycles", en_cnt, 1);
    endtask

    task automatic do_bad(input logic [7:0] b);
        exp_tx.push_back(RSP_NAK);
        push(b);
        wait_done($sformatf("bad_%0h", b));
    endtask

    task automatic rand_bytes(input int n);
        ld_bytes.delete();
        for (int i = 0; i < 4*n; i++) ld_bytes.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int we_base, wr_base, sel;
        logic [7:0] b;
        i_rst = 1'b1;
        i_tx_full = 1'b0;
        i_cpu_halt = 1'b0;
        refresh();
        repeat (3) tick();
        chk("rst_cpu_rst", o_cpu_rst, 1);
        chk("rst_cpu_en", o_cpu_en, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_wr", o_wr, 0);
        chk("rst_imem_we", o_imem_we, 0);
        chk("rst_imem_wdata", o_imem_wdata, 0);
        chk("rst_wdata", o_wdata, 0);
        chk("rst_tx_start", o_tx_start, 0);
        i_rst = 1'b0;
        tick();

        // Directed load of two known words.
        ld_bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_load(2);

        // N=0: immediate ACK, no IMEM write.
        we_base = we_cnt;
        exp_tx.push_back(RSP_ACK);
        push(CMD_LOAD);
        push(8'd0);
        wait_done("load_n0");
        chk("n0_no_imem_we", we_cnt, we_base);
        chk("n0_ack_latency_ok", (last_wr_cyc - last_pop_cyc) <= 4, 1);

        do_run(10);
        do_step();

        // NAK held off by a full TX FIFO for five cycles.
        wr_base = wr_cnt;
        i_tx_full = 1'b1;
        exp_tx.push_back(RSP_NAK);
        push(8'h41);
        repeat (5) tick();
        chk("txfull_wr_held", wr_cnt, wr_base);
        i_tx_full = 1'b0;
        wait_done("nak_txfull");
        chk("txfull_wr_once", wr_cnt, wr_base + 1);

        // Reset in the middle of a load abandons it silently.
        we_base = we_cnt;
        wr_base = wr_cnt;
        push(CMD_LOAD);
        push(8'd3);
        push(8'($urandom_range(0, 255)));
        push(8'($urandom_range(0, 255)));
        for (int i = 0; i < 50 && rx_q.size() != 0; i++) tick();
        chk("midload_rx_drained", rx_q.size(), 0);
        i_rst = 1'b1;
        tick();
        chk("midload_rst_busy", o_busy, 0);
        chk("midload_rst_cpu_rst", o_cpu_rst, 1);
        chk("midload_rst_wdata", o_imem_wdata, 0);
        i_rst = 1'b0;
        repeat (10) tick();
        chk("midload_no_write", we_cnt, we_base);
        chk("midload_no_tx", wr_cnt, wr_base);
        $display("txn midload_reset done at cycle %0d", cyc);

`ifdef DBG_PAUSE_CMD_EN
        exp_tx.push_back(RSP_HALT);
        push(CMD_RUN);
        wait_en("pause_run");
        repeat (3) tick();
        push(CMD_PAUSE);
        @(posedge clk);
        @(negedge clk);
        chk("pause_cpu_en_low", o_cpu_en, 0);
        chk("pause_popped", rx_q.size(), 0);
        wait_done("pause");
`else
        exp_tx.push_back(RSP_HALT);
        exp_tx.push_back(RSP_NAK);
        push(CMD_RUN);
        wait_en("nopause_run");
        rd_seen = 0;
        push(CMD_PAUSE);
        repeat (5) tick();
        chk("nopause_no_rd_in_run", rd_seen, 0);
        chk("nopause_p_kept", rx_q.size(), 1);
        i_cpu_halt = 1'b1;
        wait_done("nopause_halt");
        wait_done("nopause_p_nak");
        i_cpu_halt = 1'b0;
`endif

        // Randomized mix of commands against the reference model.
        for (int it = 0; it < 20; it++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: begin
                    int n;
                    n = $urandom_range(1, 4);
                    rand_bytes(n);
                    do_load(n);
                end
                1: begin
                    b = 8'($urandom_range(0, 255));
                    while (b == CMD_LOAD || b == CMD_RUN || b == CMD_STEP) b = 8'($urandom_range(0, 255));
                    do_bad(b);
                end
                2: do_step();
                default: do_run($urandom_range(1, 8));
            endcase
        end

        repeat (5) tick();
        chk("scoreboard_tx_empty", exp_tx.size(), 0);
        chk("scoreboard_imem_empty", exp_addr.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
